// File: rtl/twiddle_table_gen.sv
// twiddle_table_gen: builds an N-entry NTT twiddle table at run time.
// Entry bitrev(k) holds base^k mod Q, with base = PSI (forward) or
// PSI_INV (inverse). The table is then read through a 1-cycle
// registered port.
module twiddle_table_gen #(
  parameter int LOGN    = 4,
  parameter int WIDTH   = 17,
  parameter int Q       = 65537,
  parameter int PSI     = 2,
  parameter int PSI_INV = 32769
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inverse,
  input  logic             rd_en,
  input  logic [LOGN-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             table_valid,
  output logic             table_mode
);

  localparam int                 N       = 1 << LOGN;
  localparam logic [LOGN-1:0]    IDX_LST = LOGN'(N - 1);
  localparam logic [2*WIDTH-1:0] Q_W     = (2*WIDTH)'(Q);
  localparam logic [WIDTH-1:0]   PSI_W   = WIDTH'(PSI);
  localparam logic [WIDTH-1:0]   PSIIN_W = WIDTH'(PSI_INV);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LOGN-1:0]  idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic             gen_last;
  logic [WIDTH-1:0] mem [N];

  // Full-width product, reduced completely into [0, Q-1].
  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(prod % Q_W);
  endfunction

  // Reverse the LOGN low bits of an index.
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start only matters in IDLE; GEN runs exactly N edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     if (idx == IDX_LST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded outputs and multiplier base selection.
  always_comb begin
    busy     = (state == GEN);
    gen_last = (state == GEN) && (idx == IDX_LST);
    base     = table_mode ? PSIIN_W : PSI_W;
  end

  // Generation counter, power accumulator and table status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      acc         <= WIDTH'(1);
      done        <= 1'b0;
      table_valid <= 1'b0;
      table_mode  <= 1'b0;
    end else begin
      done <= gen_last;
      if (state == IDLE && start) begin
        idx         <= '0;
        acc         <= WIDTH'(1);
        table_mode  <= inverse;
        table_valid <= 1'b0;
      end else if (state == GEN) begin
        acc <= mod_mul(acc, base);
        idx <= idx + LOGN'(1);
        if (gen_last) table_valid <= 1'b1;
      end
    end
  end

  // Table storage: written in bit-reversed order, never reset.
  always_ff @(posedge clk) begin
    if (state == GEN) mem[bitrev(idx)] <= acc;
  end

  // Registered read port; data holds when no read is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en && table_valid) begin
      rd_data  <= mem[rd_addr];
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twiddle_table_gen.sv
// Bench for twiddle_table_gen: directed scenarios plus randomized
// generation/read traffic, checked against a power-by-repetition model.
module tb_twiddle_table_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        inverse = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [16:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        table_valid;
  logic        table_mode;

  int n_chk  = 0;
  int n_fail = 0;

  twiddle_table_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done),
    .table_valid(table_valid), .table_mode(table_mode)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: entry at address a is base^(bit-reversed a) mod Q.
  function automatic int unsigned ref_tw(input bit inv, input int addr);
    int    e = 0;
    longint v = 1;
    longint b = inv ? 32769 : 2;
    for (int j = 0; j < 4; j++) if (addr[j]) e |= (1 << (3 - j));
    for (int j = 0; j < e; j++) v = (v * b) % 65537;
    return v[31:0];
  endfunction

  task automatic read_chk(input string tag, input int addr, input int unsigned exp);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 4'(addr);
    @(negedge clk);
    rd_en = 1'b0;
    chk_val({tag, "_vld"}, 32'(rd_valid), 32'd1);
    chk_val(tag, 32'(rd_data), exp);
  endtask

  task automatic full_table_chk(input string tag, input bit inv);
    for (int a = 0; a < 16; a++) read_chk($sformatf("%s_a%0d", tag, a), a, ref_tw(inv, a));
  endtask

  // Start a generation and watch busy/done for a bounded window.
  task automatic gen_run(input string tag, input bit inv, input bit poke);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    @(negedge clk);
    start = 1'b1; inverse = inv;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) inverse = ~inv;
      start = poke && (c == 3 || c == 10);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    start = 1'b0;
    chk_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    chk_val({tag, "_done_cycle"}, 32'(done_cyc), 32'd17);
    chk_val({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk_val({tag, "_mode"}, 32'(table_mode), 32'(inv));
    chk_val({tag, "_tvalid"}, 32'(table_valid), 32'd1);
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_val("rst_rd_data", 32'(rd_data), 32'd0);
    chk_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_tvalid", 32'(table_valid), 32'd0);
    chk_val("rst_mode", 32'(table_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reads before any table exists are refused.
    rd_en = 1'b1; rd_addr = 4'd0;
    repeat (3) begin
      @(negedge clk);
      chk_val("empty_rd_valid", 32'(rd_valid), 32'd0);
      chk_val("empty_rd_data", 32'(rd_data), 32'd0);
    end
    rd_en = 1'b0;

    // Forward table.
    gen_run("fwd", 1'b0, 1'b0);
    read_chk("fwd_a0", 0, 1);
    read_chk("fwd_a1", 1, 256);
    read_chk("fwd_a8", 8, 2);
    read_chk("fwd_a15", 15, 32768);
    read_chk("fwd_a2", 2, 16);
    @(negedge clk);
    chk_val("rd_valid_drop", 32'(rd_valid), 32'd0);
    chk_val("rd_data_hold", 32'(rd_data), 32'd16);

    // Inverse table.
    gen_run("inv", 1'b1, 1'b0);
    read_chk("inv_a0", 0, 1);
    read_chk("inv_a1", 1, 65281);
    read_chk("inv_a2", 2, 61441);
    read_chk("inv_a4", 4, 49153);
    read_chk("inv_a8", 8, 32769);
    read_chk("inv_a15", 15, 65535);
    full_table_chk("inv_full", 1'b1);

    // Starts during generation are ignored.
    gen_run("poke", 1'b1, 1'b1);
    full_table_chk("poke_full", 1'b1);

    // Start and read together: read uses the old (inverse) table.
    @(negedge clk);
    start = 1'b1; inverse = 1'b0; rd_en = 1'b1; rd_addr = 4'd1;
    @(negedge clk);
    start = 1'b0; rd_en = 1'b0;
    chk_val("same_rd_valid", 32'(rd_valid), 32'd1);
    chk_val("same_rd_data", 32'(rd_data), 32'd65281);
    chk_val("same_tvalid", 32'(table_valid), 32'd0);
    chk_val("same_busy", 32'(busy), 32'd1);
    begin
      int wait_cnt = 0;
      while (!done && wait_cnt < 40) begin
        @(negedge clk);
        wait_cnt++;
      end
      chk_val("same_done_seen", 32'(done), 32'd1);
    end
    read_chk("same_new_a1", 1, 256);

    // Reset in the middle of generation.
    @(negedge clk);
    start = 1'b1; inverse = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_val("midrst_busy", 32'(busy), 32'd0);
    chk_val("midrst_tvalid", 32'(table_valid), 32'd0);
    chk_val("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gen_run("after_rst", 1'b0, 1'b0);
    full_table_chk("after_rst_full", 1'b0);

    // Back-to-back streaming reads.
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 4'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk_val($sformatf("b2b_vld%0d", k), 32'(rd_valid), 32'd1);
      chk_val($sformatf("b2b_dat%0d", k), 32'(rd_data), ref_tw(1'b0, k));
      if (k < 15) rd_addr = 4'(k + 1);
      else        rd_en = 1'b0;
    end
    @(negedge clk);
    chk_val("b2b_end_vld", 32'(rd_valid), 32'd0);

    // Randomized mode changes and random reads.
    for (int r = 0; r < 6; r++) begin
      bit inv;
      inv = 1'($urandom_range(0, 1));
      gen_run($sformatf("rnd%0d", r), inv, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 6; k++) begin
        int a;
        a = int'($urandom_range(0, 15));
        read_chk($sformatf("rnd%0d_a%0d", r, a), a, ref_tw(inv, a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/twiddle_table_gen.md
Name: twiddle_table_gen

Overview:
- Parametrised, runtime-generated twiddle-factor table for the NTT datapath.
- Replaces fixed per-size constant ROMs. On request it computes base^bitrev(k) mod Q for k = 0..N-1, using repeated modular multiplication, and stores the results in an internal N-entry table.
- Base is PSI (forward) or PSI_INV (inverse).
- Butterfly address generators then read the table with 1-cycle latency.

Parameters:
- LOGN, 4: log2 of table depth; N = 2^LOGN.
- WIDTH, 17: coefficient width; must hold Q-1.
- Q, 65537: prime modulus.
- PSI, 2: primitive 2N-th root of unity mod Q, used for forward mode.
- PSI_INV, 32769: PSI^-1 mod Q, used for inverse mode.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request generation; sampled only in IDLE.
- inverse  input  1  mode captured with start; 0 = PSI, 1 = PSI_INV.
- rd_en  input  1  read request.
- rd_addr  input  LOGN  table read address.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  rd_data is valid this cycle.
- busy  output  1  generation in progress.
- done  output  1  one-cycle pulse when generation completes.
- table_valid  output  1  table holds a complete, consistent set.
- table_mode  output  1  mode of the current/last generated table.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - rd_data=0, rd_valid=0, busy=0, done=0, table_valid=0, table_mode=0.
  - State=IDLE, counter i=0, acc=1.
  - Table memory contents are not reset.
- States: IDLE and GEN.
- IDLE:
  - start=1 at a clock edge: state<=GEN, i<=0, acc<=1, table_mode<=inverse, table_valid<=0, busy<=1.
  - start=0: remain in IDLE.
- GEN, each edge:
  - mem[bitrev_LOGN(i)] <= acc.
  - acc <= (acc * base) mod Q, where base = PSI if table_mode=0 else PSI_INV.
  - i <= i+1.
- Arithmetic: the product is computed at full 2*WIDTH bits, then reduced fully into [0, Q-1]. No lazy reduction.
- GEN exit: at the edge where i==N-1, state<=IDLE, busy<=0, done<=1 (cleared next edge), table_valid<=1.
- Timing:
  - busy is high for exactly N cycles.
  - done is asserted N+1 cycles after the start edge.
- start while busy is ignored; generation is not restarted.
- start asserted in the same cycle as done: accepted, because the FSM is already in IDLE.
- Reads:
  - If rd_en=1 and table_valid=1 at an edge: rd_data<=mem[rd_addr] and rd_valid<=1.
  - Otherwise rd_valid<=0 and rd_data holds its last value.
  - Reads are ignored while busy (table_valid=0).
  - Read latency is 1 cycle; back-to-back reads sustain one result per cycle.
- start and rd_en in the same IDLE cycle with table_valid=1: the read is served from the old table, and table_valid drops on the same edge.
- Reset mid-GEN: return to IDLE with table_valid=0. A fresh start regenerates the full table.
- bitrev_LOGN(i) reverses the LOGN low bits. i wraps only via the exit condition and never exceeds N-1.

Test Plan:
- Reset, then rd_en=1 with rd_addr=0 → rd_valid stays 0 and rd_data=0; all outputs are 0 immediately on rst_n falling, with no clock edge required.
- start with inverse=0 (defaults) → busy high for 16 cycles, done pulses at cycle 17, table_mode=0. Reads must return: addr0=1, addr1=256, addr8=2, addr15=32768, addr2=16.
- start with inverse=1 → reads must return: addr0=1, addr1=65281, addr2=61441, addr4=49153, addr8=32769, addr15=65535. All 16 entries checked against a golden model.
- start asserted again at cycles 3 and 10 of GEN → ignored: done occurs once at cycle 17 and table contents are unchanged from a single run. Same-cycle start and read with table_valid=1 → the read returns the old-table value.
- rst_n pulsed low at GEN cycle 8 → busy=0 and table_valid=0 immediately. Then start with inverse=0 → table is correct and done fires 17 cycles after that start.
- Back-to-back reads of addr 0..15 with rd_en held high → 16 consecutive rd_valid cycles, each data value appearing 1 cycle after its address.
